// File: rtl/switch_event_gen.sv
// Push-switch conditioning: two-flop synchroniser, debounce, and press/hold-to-repeat
// event generation. Every channel is an independent copy of the same pipeline.
module switch_event_gen #(
  parameter int unsigned NUM_SWITCHES   = 3,
  parameter int unsigned DEBOUNCE_LIMIT = 25000,
  parameter int unsigned HOLD_LIMIT     = 12500000,
  parameter int unsigned REPEAT_LIMIT   = 2500000,
  parameter int unsigned REPEAT_EN      = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Level,
  output logic [NUM_SWITCHES-1:0] o_Press,
  output logic [NUM_SWITCHES-1:0] o_Repeat
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_LIMIT);
  localparam int unsigned HC_MAX = (HOLD_LIMIT > REPEAT_LIMIT) ? HOLD_LIMIT : REPEAT_LIMIT;
  localparam int unsigned HC_W   = $clog2(HC_MAX);

  localparam logic [DB_W-1:0] DB_TC   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HC_W-1:0] HOLD_TC = HC_W'(HOLD_LIMIT - 1);
  localparam logic [HC_W-1:0] REP_TC  = HC_W'(REPEAT_LIMIT - 1);
  localparam logic            RPT_ON  = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  for (genvar g = 0; g < int'(NUM_SWITCHES); g++) begin : g_ch
    logic            s_meta;
    logic            s_sync;
    logic [DB_W-1:0] db_cnt;
    logic            level;
    logic            db_tc_c;
    logic            rise_c;
    logic            fall_c;

    state_t          state_q;
    state_t          state_d;
    logic [HC_W-1:0] hold_cnt_q;
    logic [HC_W-1:0] hold_cnt_d;
    logic            press_q;
    logic            press_d;
    logic            rep_q;
    logic            rep_d;

    // Level flips on the edge where the mismatch has lasted DEBOUNCE_LIMIT cycles
    assign db_tc_c = (s_sync != level) && (db_cnt == DB_TC);
    assign rise_c  = db_tc_c && !level;
    assign fall_c  = db_tc_c && level;

    // Synchroniser and debounce counter
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        s_meta <= 1'b0;
        s_sync <= 1'b0;
        db_cnt <= '0;
        level  <= 1'b0;
      end else begin
        s_meta <= i_Switch[g];
        s_sync <= s_meta;
        if (s_sync == level) begin
          db_cnt <= '0;
        end else if (db_tc_c) begin
          db_cnt <= '0;
          level  <= ~level;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    // Event FSM state, shared hold/repeat counter and output pulse registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        state_q    <= IDLE;
        hold_cnt_q <= '0;
        press_q    <= 1'b0;
        rep_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        press_q    <= press_d;
        rep_q      <= rep_d;
      end
    end

    // Next-state: release always wins over a coincident repeat terminal count
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      rep_d      = 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_c) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            press_d    = 1'b1;
          end
        end
        HOLD: begin
          if (fall_c) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HOLD_TC) begin
            if (RPT_ON) begin
              state_d    = REPEAT;
              hold_cnt_d = '0;
              press_d    = 1'b1;
              rep_d      = 1'b1;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
        end
        REPEAT: begin
          if (fall_c) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == REP_TC) begin
            hold_cnt_d = '0;
            press_d    = 1'b1;
            rep_d      = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end

    assign o_Level[g]  = level;
    assign o_Press[g]  = press_q;
    assign o_Repeat[g] = rep_q;
  end

endmodule
